// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Arbiter FSM encodings and the common word width live here so the
// top and any helpers agree on them.
package mem_port_arbiter_pkg;

    localparam int ARB_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_I_ACC = 2'd1,
        ARB_D_ACC = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // True while a memory access is outstanding (strobes may be high).
    function automatic logic arb_in_access(input arb_state_t s);
        return (s == ARB_I_ACC) || (s == ARB_D_ACC);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog for the memory port arbiter.
// Counts consecutive cycles with run=1; expired rises combinationally in
// the TIMEOUT_CYCLES-th such cycle so the arbiter can leave on that edge.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Cycle counter, cleared whenever no access is in flight.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified-memory port arbiter: IF-stage fetch vs MEM-stage load/store.
// Data wins by default; fetch is forced through after STARVE_LIMIT data
// grants made while it was waiting. Optional access watchdog is built
// when MEM_ARB_TIMEOUT_EN is defined.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int WORD_SIZE      = ARB_WORD_SIZE,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 mem_err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t           state, state_next;
    logic [3:0]           starve_cnt;
    logic [WORD_SIZE-1:0] addr_q, wdata_q, resp_q;
    logic                 we_q;
    logic                 owner_d;
    logic                 err_q;

    logic grant_i, grant_d, capture, timeout, expired;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (arb_in_access(state)),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    // Next-state and grant decode; requests are only looked at in IDLE.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_req && !(i_req && starve_cnt == STARVE_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = ARB_D_ACC;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = ARB_I_ACC;
                end
            end
            ARB_I_ACC, ARB_D_ACC: begin
                if (mem_ready) begin
                    capture    = 1'b1;
                    state_next = ARB_RESP;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // State, latched request, starvation counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_d    <= 1'b0;
            resp_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                addr_q     <= i_addr;
                we_q       <= 1'b0;
                owner_d    <= 1'b0;
                err_q      <= 1'b0;
                starve_cnt <= '0;
            end
            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
                owner_d <= 1'b1;
                err_q   <= 1'b0;
                if (i_req && starve_cnt < STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
            if (capture) begin
                resp_q <= mem_rdata;
            end
            if (timeout) begin
                resp_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign mem_readM   = (state == ARB_I_ACC) || (state == ARB_D_ACC && !we_q);
    assign mem_writeM  = (state == ARB_D_ACC) && we_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_ack       = (state == ARB_RESP) && !owner_d;
    assign d_ack       = (state == ARB_RESP) && owner_d;
    assign i_data      = resp_q;
    assign d_rdata     = resp_q;
    assign busy        = (state != ARB_IDLE);
    assign mem_err     = (state == ARB_RESP) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Expected acks are queued as
// stimulus is issued; a negedge monitor pops and compares each ack.
// The timeout scenario is included when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_data, d_rdata, mem_address, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_readM, mem_writeM, mem_ready, busy, mem_err;

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [15:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_n   = 0;
    logic [15:0] mem_model [256];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORD_SIZE     (16),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_ack      (i_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_readM  (mem_readM),
        .mem_writeM (mem_writeM),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .mem_err    (mem_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input bit is_d, input bit chk_data, input logic [15:0] data, input bit err);
        exp_t e;
        e.is_d     = is_d;
        e.chk_data = chk_data;
        e.data     = data;
        e.err      = err;
        sb.push_back(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit want_d, input int budget, output int cycles);
        cycles = 0;
        while (((want_d ? d_ack : i_ack) !== 1'b1) && cycles < budget) begin
            cyc();
            cycles++;
        end
        chk(want_d ? "d_ack_seen" : "i_ack_seen", {31'd0, (want_d ? d_ack : i_ack)}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, {30'd0, mem_readM, mem_writeM}, 32'd0);
        chk({tag, "_acks"},    {30'd0, i_ack, d_ack}, 32'd0);
        chk({tag, "_busy"},    {30'd0, busy, mem_err}, 32'd0);
        chk({tag, "_addr"},    {16'd0, mem_address}, 32'd0);
        chk({tag, "_wdata"},   {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_rdata"},   {i_data, d_rdata}, 32'd0);
    endtask

    // Memory model: ready after wait_n extra cycles of an asserted strobe.
    initial begin
        int acc = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_readM || mem_writeM) begin
                if (acc == wait_n) begin
                    mem_ready = 1'b1;
                    if (mem_writeM) begin
                        mem_model[mem_address[7:0]] = mem_wdata;
                        mem_rdata = 16'hDEAD;
                    end else begin
                        mem_rdata = mem_model[mem_address[7:0]];
                    end
                end else begin
                    mem_ready = 1'b0;
                end
                acc++;
            end else begin
                acc       = 0;
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Ack monitor: pops the scoreboard on every ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                chk("ack_overlap", {31'd0, i_ack & d_ack}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none at %0t", i_ack, d_ack, $time);
                end else begin
                    e = sb.pop_front();
                    chk("ack_kind", {31'd0, d_ack}, {31'd0, e.is_d});
                    if (e.chk_data) begin
                        chk("ack_data", {16'd0, (d_ack ? d_rdata : i_data)}, {16'd0, e.data});
                    end
                    chk("ack_err", {31'd0, mem_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int wr_cnt;
        int wd_bad;
        int acks;
        int dacks;
        logic [5:0] order;

        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_model[8'h10] = 16'h6001;
        mem_model[8'h11] = 16'h7A02;
        mem_model[8'h40] = 16'h1234;

        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) cyc();
        chk_all_zero("reset");
        reset = 1'b0;
        cyc();

        // Fetch only, zero-wait memory.
        i_req = 1; i_addr = 16'h0010;
        push(0, 1, 16'h6001, 0);
        cyc();
        chk("f1_readM", {31'd0, mem_readM}, 32'd1);
        chk("f1_addr", {16'd0, mem_address}, 32'h0010);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        chk("f1_no_early_ack", {31'd0, i_ack}, 32'd0);
        cyc();
        chk("f1_ack_cycle2", {31'd0, i_ack}, 32'd1);
        i_req = 0;
        cyc();
        chk("f1_idle_cycle3", {30'd0, busy, i_ack}, 32'd0);

        // Simultaneous requests: data first, fetch after the dead RESP cycle.
        i_req = 1; i_addr = 16'h0011;
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        push(1, 1, 16'h1234, 0);
        push(0, 1, 16'h7A02, 0);
        wait_ack(1, 20, n);
        chk("sim_data_first_latency", n, 32'd2);
        d_req = 0;
        wait_ack(0, 20, n);
        chk("sim_fetch_gap", n, 32'd3);
        i_req = 0;
        cyc();

        // Store with three wait cycles.
        wait_n = 3;
        d_req = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 16'hBEEF;
        push(1, 0, 16'h0000, 0);
        wr_cnt = 0; wd_bad = 0; n = 0;
        while (d_ack !== 1'b1 && n < 20) begin
            cyc();
            n++;
            if (mem_writeM) begin
                wr_cnt++;
                if (mem_wdata !== 16'hBEEF || mem_address !== 16'h0050 || mem_readM) wd_bad++;
            end
        end
        chk("st_ack_cycle", n, 32'd5);
        chk("st_write_cycles", wr_cnt, 32'd4);
        chk("st_wdata_stable", wd_bad, 32'd0);
        d_req = 0; d_we = 0;
        wait_n = 0;
        cyc();
        d_req = 1; d_addr = 16'h0050;
        push(1, 1, 16'hBEEF, 0);
        wait_ack(1, 20, n);
        d_req = 0;
        cyc();

        // Starvation: four data grants, then fetch forced through.
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        i_req = 1; i_addr = 16'h0011;
        for (int i = 0; i < 4; i++) push(1, 1, 16'h1234, 0);
        push(0, 1, 16'h7A02, 0);
        push(1, 1, 16'h1234, 0);
        acks = 0; order = '0; n = 0;
        while (acks < 6 && n < 60) begin
            cyc();
            n++;
            if (i_ack || d_ack) begin
                order[acks] = d_ack;
                acks++;
                if (i_ack) i_req = 0;
                if (acks == 6) d_req = 0;
            end
        end
        chk("starve_ack_count", acks, 32'd6);
        chk("starve_order", {26'd0, order}, 32'b101111);
        cyc();

        // Reset in cycle 2 of a stalled load: no ack, everything cleared.
        wait_n = 1000;
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        cyc();
        chk("rst_load_strobe", {31'd0, mem_readM}, 32'd1);
        cyc();
        reset = 1; d_req = 0;
        cyc();
        chk_all_zero("rst_mid");
        reset = 0;
        wait_n = 0;
        dacks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (d_ack) dacks++;
        end
        chk("rst_no_ack", dacks, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: memory never ready, ack after 8 access cycles.
        wait_n = 1000;
        i_req = 1; i_addr = 16'h0010;
        push(0, 1, 16'h0000, 1);
        wait_ack(0, 30, n);
        chk("to_ack_cycle", n, 32'd9);
        i_req = 0;
        wait_n = 0;
        cyc();
`endif

        repeat (3) cyc();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory of the pipelined TSC CPU between the IF-stage instruction fetch and the MEM-stage data access (LWD/SWD, driven by `d_readM`/`d_writeM` from the control unit). Fixed data-over-fetch priority with a bounded-starvation override, a registered memory request, and a one-cycle acknowledge back to the winning requester. The hazard logic stalls whichever stage is waiting on its `*_ack`.

## Interface
- `WORD_SIZE`, 16, address/data width
- `STARVE_LIMIT`, 4, consecutive data grants with fetch pending before fetch is forced to win (1..15)
- `TIMEOUT_CYCLES`, 64, watchdog limit in cycles (used only with the macro)

Clock/reset: one clock; reset is synchronous and active-high.

- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high
- `i_req` in 1: fetch request, held until `i_ack`
- `i_addr` in WORD_SIZE: fetch address
- `i_data` out WORD_SIZE: fetched word, valid while `i_ack`=1
- `i_ack` out 1: one-cycle fetch completion
- `d_req` in 1: data request, held until `d_ack`
- `d_we` in 1: 1 = store (SWD), 0 = load (LWD)
- `d_addr` in WORD_SIZE: data address
- `d_wdata` in WORD_SIZE: store data
- `d_rdata` out WORD_SIZE: load data, valid while `d_ack`=1
- `d_ack` out 1: one-cycle data completion
- `mem_readM` out 1: memory read strobe
- `mem_writeM` out 1: memory write strobe
- `mem_address` out WORD_SIZE: memory address
- `mem_wdata` out WORD_SIZE: memory write data
- `mem_rdata` in WORD_SIZE: memory read data, valid with `mem_ready`
- `mem_ready` in 1: memory completion, one cycle
- `busy` out 1: state != IDLE
- `mem_err` out 1: timeout flag, with the ack (tied 0 without the macro)

## Operation
- States: IDLE, I_ACC, D_ACC, RESP.
- IDLE: if either request is high, the arbiter latches the winner's address, write data, and we into registers and moves to I_ACC or D_ACC.
  - Winner is data, unless `i_req`=1 and `starve_cnt`==STARVE_LIMIT, in which case fetch wins.
- I_ACC drives `mem_readM`=1. D_ACC drives `mem_readM`=!we and `mem_writeM`=we. Address and data outputs come from the latched registers and stay stable for the whole access.
- In an ACC state, `mem_ready`=1 captures `mem_rdata` into the response register, clears the strobes, and moves to RESP.
- RESP pulses the matching `*_ack` for exactly one cycle, then returns to IDLE.
  - Requests are not sampled in RESP, so a held-over request is never double-served.
- `starve_cnt` (4 bit):
  - +1 on each data grant made while `i_req`=1 (saturates at STARVE_LIMIT).
  - Cleared on any fetch grant.
- `mem_ready` in IDLE or RESP is ignored.
- Store ack returns `d_rdata` = last captured value. This value is don't-care.
- Requesters must not change address or data while their request is pending. Dropping a request mid-access does not cancel it; the ack is still issued.

## Timing
- Reset values: state IDLE; all strobes, acks, `busy`, and `mem_err` 0; `mem_address`, `mem_wdata`, `i_data`, `d_rdata` 0; `starve_cnt` 0.
- Cycle 0: request seen in IDLE.
- Cycle 1: strobe asserted.
- Ready sampled at the end of cycle k (k ≥ 1). Ack occurs in cycle k+1.
- Latency is k+1 cycles. Best case is request to ack = 2 cycles with zero-wait memory (ready in cycle 1).
- Back-to-back accesses occupy k+2 cycles each, because the RESP cycle is dead.
- Simultaneous `i_req` and `d_req`: data first, then fetch in the next IDLE (fetch stays pending).
- Reset mid-access: the next edge forces IDLE. Strobes drop, no ack is issued, and the transaction is lost. The pipeline is flushed by the same reset.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: the watchdog counts cycles in I_ACC/D_ACC. On reaching TIMEOUT_CYCLES without `mem_ready`, the arbiter:
  - drops the strobes,
  - moves to RESP with response data 0,
  - asserts `mem_err`=1 together with the ack.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter is built, the arbiter waits indefinitely, and `mem_err` is constant 0.

## Structure
- Add the state encodings (`ARB_IDLE`, `ARB_I_ACC`, `ARB_D_ACC`, `ARB_RESP`) to `constants.v` next to the existing REGDST/PCSRC defines. `WORD_SIZE` is shared from there as well.
- One sub-module, `mem_arb_watchdog` (clk, reset, run, expired), instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch only, `i_addr`=16'h0010, memory ready in cycle 1 with 16'h6001 → `mem_readM` in cycle 1, `i_ack`=1 with `i_data`=16'h6001 in cycle 2, `busy` back to 0 in cycle 3.
- Simultaneous requests: `d_req` load 16'h0040 and `i_req` 16'h0011 → data served first (`d_ack`), then fetch (`i_ack`) with no overlap.
- Store: `d_we`=1, addr 16'h0050, wdata 16'hBEEF, ready after 3 wait cycles → `mem_writeM`=1 for 4 cycles, `mem_wdata`=16'hBEEF, single `d_ack`.
- Starvation: `d_req` permanently high and `i_req` high, STARVE_LIMIT=4 → 4 data acks, then 1 fetch ack, then data resumes.
- Reset asserted in cycle 2 of a pending load → next cycle all outputs 0 and state IDLE; no `d_ack` ever issues.
- With `MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, `mem_ready` never asserted → ack in the cycle after the 8th access cycle, `mem_err`=1, data 16'h0000.
